// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// opcode constants, ALU operation classes, ALU control codes and the
// mux-select encodings driven by the FSM.
package uc_pkg;

  // State encoding. The enum below is built on these codes so the state
  // register is typed while the numeric encoding stays in one place.
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;

  typedef enum logic [3:0] {
    S_FETCH    = ST_FETCH,
    S_DECODE   = ST_DECODE,
    S_MEMADR   = ST_MEMADR,
    S_MEMREAD  = ST_MEMREAD,
    S_MEMWB    = ST_MEMWB,
    S_MEMWRITE = ST_MEMWRITE,
    S_EXECR    = ST_EXECR,
    S_EXECI    = ST_EXECI,
    S_ALUWB    = ST_ALUWB,
    S_BEQ      = ST_BEQ,
    S_JAL      = ST_JAL
  } state_e;

  // Supported opcodes.
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation class requested by the FSM.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result mux.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALU operand A mux.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU operand B mux.
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, independent of state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aluDeco.sv
// ALU decoder: turns the FSM's ALU operation class plus the instruction
// funct fields into a 3-bit ALU control code.
//   alu_op      in  2  operation class (add / sub / by funct)
//   funct3      in  3  instruction funct3
//   op5         in  1  opcode bit 5 (distinguishes R-type from I-type)
//   funct7b5    in  1  funct7 bit 5
//   alu_control out 3  ALU control code
module aluDeco
  import uc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can request subtract; addi ignores funct7.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: a single registered state plus a combinational
// output/next-state block that sequences fetch, decode and the per-class
// execute steps of a small RISC-V subset (lw, sw, R-type, I-type ALU,
// beq, jal).
//   clk, reset   in   clock; synchronous active-high reset
//   op, f3, f7   in   instruction fields (opcode, funct3, funct7 bit 5)
//   zero         in   ALU zero flag
//   memReady     in   memory access completes this cycle
//   pcWrite      out  PC load enable (pcUpdate or taken branch)
//   adrSrc       out  memory address select
//   memWrite     out  data memory write strobe
//   irWrite      out  instruction register / oldPC load enable
//   resSrc       out  result mux select
//   aluSrcA/B    out  ALU operand selects
//   ALUcontrol   out  ALU operation code
//   immSrc       out  immediate format
//   regWrite     out  register file write enable
//   illegal      out  one-cycle pulse on an unsupported opcode
module uc_multiciclo
  import uc_pkg::*;
#(
  // 1: memory states wait for memReady. 0: memory always treated as ready.
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic       f7,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] ALUcontrol,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic       illegal
);

  state_e     state;
  state_e     next_state;
  logic       ready;
  logic       pc_update;
  logic       branch;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       ir_write_raw;
  logic       illegal_raw;
  logic [1:0] alu_op;

  assign ready = (MEM_WAIT == 0) ? 1'b1 : memReady;

  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    illegal_raw   = 1'b0;
    adrSrc        = 1'b0;
    resSrc        = RES_ALUOUT;
    aluSrcA       = SRCA_PC;
    aluSrcB       = SRCB_REG;
    alu_op        = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        adrSrc  = 1'b0;
        aluSrcA = SRCA_PC;
        aluSrcB = SRCB_FOUR;
        alu_op  = ALUOP_ADD;
        resSrc  = RES_ALU;
        // Capture the instruction and advance PC only once it has arrived.
        if (ready) begin
          ir_write_raw = 1'b1;
          pc_update    = 1'b1;
          next_state   = S_DECODE;
        end else begin
          next_state   = S_FETCH;
        end
      end

      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default: begin
            next_state  = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        aluSrcA    = SRCA_REG;
        aluSrcB    = SRCB_IMM;
        alu_op     = ALUOP_ADD;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        resSrc     = RES_ALUOUT;
        adrSrc     = 1'b1;
        next_state = ready ? S_MEMWB : S_MEMREAD;
      end

      S_MEMWB: begin
        resSrc        = RES_DATA;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end

      S_MEMWRITE: begin
        resSrc        = RES_ALUOUT;
        adrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        next_state    = ready ? S_FETCH : S_MEMWRITE;
      end

      S_EXECR: begin
        aluSrcA    = SRCA_REG;
        aluSrcB    = SRCB_REG;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end

      S_EXECI: begin
        aluSrcA    = SRCA_REG;
        aluSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        resSrc        = RES_ALUOUT;
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end

      S_BEQ: begin
        // PC loads the target held in ALUOut only when the compare is equal.
        aluSrcA    = SRCA_REG;
        aluSrcB    = SRCB_REG;
        alu_op     = ALUOP_SUB;
        resSrc     = RES_ALUOUT;
        branch     = 1'b1;
        next_state = S_FETCH;
      end

      S_JAL: begin
        // PC takes the jump target from ALUOut; ALU forms oldPC+4 for rd.
        aluSrcA    = SRCA_OLDPC;
        aluSrcB    = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        resSrc     = RES_ALUOUT;
        pc_update  = 1'b1;
        next_state = S_ALUWB;
      end

      default: next_state = S_FETCH;
    endcase
  end

  aluDeco u_alu_deco (
    .alu_op      (alu_op),
    .funct3      (f3),
    .op5         (op[5]),
    .funct7b5    (f7),
    .alu_control (ALUcontrol)
  );

  assign immSrc = imm_src_of(op);

  // Strobes are suppressed during reset even though the state register
  // only returns to FETCH at the next edge.
  assign pcWrite  = ~reset & (pc_update | (branch & zero));
  assign memWrite = ~reset & mem_write_raw;
  assign regWrite = ~reset & reg_write_raw;
  assign irWrite  = ~reset & ir_write_raw;
  assign illegal  = ~reset & illegal_raw;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo. The driver walks each instruction
// through the steps an instruction of its class takes, pushes the output
// vector those steps imply for every cycle, and a negedge monitor compares
// the DUT outputs against the queue.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zero;
  logic       memReady;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] ALUcontrol;

  uc_multiciclo #(.MEM_WAIT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .f3         (f3),
    .f7         (f7),
    .zero       (zero),
    .memReady   (memReady),
    .pcWrite    (pcWrite),
    .adrSrc     (adrSrc),
    .memWrite   (memWrite),
    .irWrite    (irWrite),
    .resSrc     (resSrc),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .ALUcontrol (ALUcontrol),
    .immSrc     (immSrc),
    .regWrite   (regWrite),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef enum int {
    PH_FETCH, PH_DECODE, PH_ADDR, PH_LOAD, PH_LOADWB, PH_STORE,
    PH_EXR, PH_EXI, PH_WB, PH_BRANCH, PH_JUMP
  } phase_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] res_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_ctl;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t  o;
    phase_e ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   zero_force = -1;

  function automatic bit supported(input logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // ALU code for the "use the funct fields" steps.
  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] fn3,
                                           input logic fn7);
    case (fn3)
      3'b000:  return (o == RT && fn7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t model(input phase_e ph, input logic [6:0] o, input logic [2:0] fn3,
                                  input logic fn7, input logic z, input logic rdy,
                                  input logic rst);
    outs_t e = '0;
    e.imm_src = imm_of(o);
    case (ph)
      PH_FETCH:  begin e.src_b = 2'b10; e.res_src = 2'b10; e.ir_write = rdy; e.pc_write = rdy; end
      PH_DECODE: begin e.src_a = 2'b01; e.src_b = 2'b01; e.illegal = !supported(o); end
      PH_ADDR:   begin e.src_a = 2'b10; e.src_b = 2'b01; end
      PH_LOAD:   e.adr_src = 1'b1;
      PH_LOADWB: begin e.res_src = 2'b01; e.reg_write = 1'b1; end
      PH_STORE:  begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      PH_EXR:    begin e.src_a = 2'b10; e.alu_ctl = funct_alu(o, fn3, fn7); end
      PH_EXI:    begin e.src_a = 2'b10; e.src_b = 2'b01; e.alu_ctl = funct_alu(o, fn3, fn7); end
      PH_WB:     e.reg_write = 1'b1;
      PH_BRANCH: begin e.src_a = 2'b10; e.alu_ctl = 3'b001; e.pc_write = z; end
      PH_JUMP:   begin e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1; end
      default:   e = '0;
    endcase
    if (rst) begin
      e.pc_write = 0; e.mem_write = 0; e.ir_write = 0; e.reg_write = 0; e.illegal = 0;
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, record what the DUT must show, advance.
  task automatic drive_cycle(input phase_e ph, input logic rdy, input logic rst);
    exp_t e;
    zero     = (zero_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_force);
    memReady = rdy;
    reset    = rst;
    e.ph = ph;
    e.o  = model(ph, op, f3, f7, zero, rdy, rst);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic mem_step(input phase_e ph, input int stalls);
    repeat (stalls) drive_cycle(ph, 1'b0, 1'b0);
    drive_cycle(ph, 1'b1, 1'b0);
  endtask

  // memReady is randomised in steps that must ignore it.
  task automatic plain_step(input phase_e ph);
    drive_cycle(ph, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] fn3, input logic fn7,
                           input int fetch_stalls, input int mem_stalls);
    phase_e path[$];
    op = o; f3 = fn3; f7 = fn7;
    if (o == LW) begin path.push_back(PH_ADDR); path.push_back(PH_LOAD); path.push_back(PH_LOADWB); end
    else if (o == SW) begin path.push_back(PH_ADDR); path.push_back(PH_STORE); end
    else if (o == RT) begin path.push_back(PH_EXR); path.push_back(PH_WB); end
    else if (o == IT) begin path.push_back(PH_EXI); path.push_back(PH_WB); end
    else if (o == BQ) path.push_back(PH_BRANCH);
    else if (o == JL) begin path.push_back(PH_JUMP); path.push_back(PH_WB); end
    mem_step(PH_FETCH, fetch_stalls);
    plain_step(PH_DECODE);
    foreach (path[i]) begin
      if (path[i] == PH_LOAD || path[i] == PH_STORE) mem_step(path[i], mem_stalls);
      else plain_step(path[i]);
    end
  endtask

  // Load or store interrupted by reset while waiting on memory.
  task automatic reset_mid_mem(input logic [6:0] o);
    phase_e ph;
    ph = (o == LW) ? PH_LOAD : PH_STORE;
    op = o; f3 = 3'($urandom); f7 = 1'($urandom);
    mem_step(PH_FETCH, 0);
    plain_step(PH_DECODE);
    plain_step(PH_ADDR);
    drive_cycle(ph, 1'b0, 1'b0);
    drive_cycle(ph, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    outs_t act;
    cyc++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pcWrite, adrSrc, memWrite, irWrite, resSrc, aluSrcA, aluSrcB,
             ALUcontrol, immSrc, regWrite, illegal};
      n_cmp++;
      if (act !== e.o) begin
        n_bad++;
        $display("FAIL cycle %0d step %s op=%b f3=%b f7=%b zero=%b rdy=%b rst=%b: got %b want %b",
                 cyc, e.ph.name(), op, f3, f7, zero, memReady, reset, act, e.o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [7];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BQ; ops[5] = JL;
    ops[6] = 7'b1111111;
    reset = 1'b1; op = 7'd0; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; memReady = 1'b0;
    @(posedge clk);
    #1;
    // Held in reset: FETCH selects with all strobes forced low.
    drive_cycle(PH_FETCH, 1'b1, 1'b1);
    drive_cycle(PH_FETCH, 1'b0, 1'b1);

    // Directed cases.
    run_instr(LW, 3'b010, 1'b0, 0, 3);        // load with three memory stalls
    run_instr(RT, 3'b000, 1'b1, 1, 0);        // R-type subtract
    run_instr(IT, 3'b000, 1'b1, 0, 0);        // addi never subtracts
    run_instr(RT, 3'b111, 1'b0, 0, 0);
    run_instr(RT, 3'b110, 1'b0, 0, 0);
    run_instr(IT, 3'b010, 1'b0, 0, 0);
    run_instr(RT, 3'b001, 1'b1, 0, 0);        // unlisted funct3 -> add
    zero_force = 1; run_instr(BQ, 3'b000, 1'b0, 0, 0);
    zero_force = 0; run_instr(BQ, 3'b000, 1'b0, 0, 0);
    zero_force = -1;
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0); // unsupported opcode
    run_instr(JL, 3'b000, 1'b0, 0, 0);
    run_instr(SW, 3'b010, 1'b0, 2, 2);
    reset_mid_mem(SW);
    run_instr(SW, 3'b010, 1'b0, 0, 0);
    reset_mid_mem(LW);
    run_instr(LW, 3'b010, 1'b0, 0, 0);

    // Randomised instruction stream.
    for (int n = 0; n < 80; n++) begin
      logic [6:0] o;
      o = ops[$urandom_range(0, 6)];
      if (o == 7'b1111111) o = 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uc_multiciclo.md
UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter: MEM_WAIT, default 1, meaning 1 = memory states hold until memReady, 0 = memReady ignored and treated as 1.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 f3  input  3  funct3 field.
REQ-006 f7  input  1  funct7 bit 5.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 memReady  input  1  memory access complete this cycle.
REQ-009 pcWrite  output  1  PC load enable, equal to pcUpdate OR (branch AND zero).
REQ-010 adrSrc  output  1  memory address select: 0 = PC, 1 = result.
REQ-011 memWrite  output  1  data memory write strobe.
REQ-012 irWrite  output  1  instruction register and oldPC load enable.
REQ-013 resSrc  output  2  result mux: 00 = ALUOut, 01 = data register, 10 = ALU result.
REQ-014 aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = register A.
REQ-015 aluSrcB  output  2  00 = register B, 01 = immediate, 10 = constant 4.
REQ-016 ALUcontrol  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-017 immSrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type; decoded combinationally from op in every state.
REQ-018 regWrite  output  1  register file write enable.
REQ-019 illegal  output  1  high for exactly one cycle, in the cycle the FSM leaves DECODE toward FETCH because op is unsupported.

Function
REQ-020 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-021 FETCH: adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp add, resSrc=10. irWrite and pcUpdate are asserted only when memReady=1. Stay in FETCH while memReady=0; go to DECODE when memReady=1.
REQ-022 DECODE: aluSrcA=01, aluSrcB=01, aluOp add (branch target). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other op -> FETCH, with illegal asserted.
REQ-023 MEMADR: aluSrcA=10, aluSrcB=01, aluOp add. Next is MEMREAD for op 0000011, else MEMWRITE.
REQ-024 MEMREAD: resSrc=00, adrSrc=1. Hold until memReady=1, then go to MEMWB.
REQ-025 MEMWB: resSrc=01, regWrite=1, then go to FETCH.
REQ-026 MEMWRITE: resSrc=00, adrSrc=1, memWrite=1 every cycle in the state. Hold until memReady=1, then go to FETCH.
REQ-027 EXECR: aluSrcA=10, aluSrcB=00, aluOp funct. EXECI: aluSrcA=10, aluSrcB=01, aluOp funct. Both go to ALUWB.
REQ-028 ALUWB: resSrc=00, regWrite=1, then go to FETCH.
REQ-029 BEQ: aluSrcA=10, aluSrcB=00, aluOp sub, resSrc=00, branch=1, so pcWrite follows zero. Then go to FETCH.
REQ-030 JAL: aluSrcA=01, aluSrcB=10, aluOp add, resSrc=00, pcUpdate=1, then go to ALUWB.
REQ-031 ALU decode, aluOp 00 -> add, 01 -> sub, 10 -> by f3:
- f3 000: sub if op[5] AND f7 are both 1, else add
- f3 010 -> slt
- f3 110 -> or
- f3 111 -> and
- any other f3 -> 000.
REQ-032 All enables default 0 and all selects default 00 in any state that does not assign them; no output latches.
REQ-033 Latency (MEM_WAIT=0): R/I-type 4 cycles, lw 5, sw 4, beq 3, jal 4.
REQ-034 Unreachable state encodings transition to FETCH on the next edge.

Reset
REQ-035 reset=1 at a clock edge forces FETCH on that edge, overriding any transition, including mid-MEMWRITE or mid-MEMREAD.
REQ-036 While reset=1, memWrite, regWrite, irWrite, pcWrite and illegal are forced to 0 combinationally.
REQ-037 The first FETCH cycle after reset deasserts behaves per REQ-021.

Structure
REQ-038 The state encoding (4-bit localparams), opcode constants, aluOp codes and ALUcontrol codes reside in shared package uc_pkg.
REQ-039 ALU decoding (REQ-031) is the existing sub-module aluDeco, instantiated unchanged; the FSM is a single registered state plus a combinational output block.

Verification
REQ-040 lw, op=0000011, memReady stuck 0 for 3 cycles in MEMREAD -> FETCH, DECODE, MEMADR, MEMREAD x4, MEMWB. regWrite=1 only in MEMWB.
REQ-041 R-type sub (op=0110011, f3=000, f7=1) -> ALUcontrol=001 in EXECR; regWrite=1 one cycle later.
REQ-042 beq with zero=1 -> pcWrite=1 in BEQ. With zero=0 -> pcWrite=0. Both return to FETCH.
REQ-043 op=1111111 -> illegal=1 exactly one cycle and no write strobe, then back in FETCH.
REQ-044 reset=1 asserted during MEMWRITE -> memWrite=0 in that same cycle and state=FETCH after the edge.
REQ-045 jal -> sequence FETCH, DECODE, JAL, ALUWB, with pcWrite=1 in JAL and regWrite=1 in ALUWB.
